average_csr_master: RTL
=======================

# average_csr_master

Bus initiator for the average accelerator's memory-mapped register port. Accepts single read/write commands on a valid/ready command channel and drives the addr/ren/wen/wdata strobes of the register slave. It captures rdata and the address-error flags that the slave registers one cycle later, and returns them on a valid/ready response channel. It sits between the host-side command source (test sequencer or bridge) and the average register block. It also keeps a saturating count of address errors.

## Interface
- ADDR_BITS, 12, bus address width
- DATA_BITS, 32, bus data width
- ERR_COUNT_BITS, 16, width of the saturating error counter
- clk  in  1  clock; all logic on rising edge
- srst  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_BITS  byte address
- cmd_wdata  in  DATA_BITS  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_BITS  read data (0 for writes)
- rsp_error  out  1  slave flagged address out of range
- addr  out  ADDR_BITS  bus address to slave
- ren  out  1  bus read strobe
- wen  out  1  bus write strobe
- wdata  out  DATA_BITS  bus write data
- rdata  in  DATA_BITS  slave read data (registered in slave)
- waddr_error  in  1  slave write-address error (registered in slave)
- raddr_error  in  1  slave read-address error (registered in slave)
- err_count  out  ERR_COUNT_BITS  saturating count of responses with rsp_error=1

## Operation
- FSM states are IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: register addr/wdata from the command. Set wen=cmd_write, ren=~cmd_write. Latch cmd_write. Go to ISSUE.
- **ISSUE**
  - Exactly one strobe cycle; the slave samples at the end of it.
  - Clear ren/wen at the exiting edge. Go to CAPTURE.
- **CAPTURE**
  - The slave's registered outputs are valid.
  - Register rsp_error = latched write ? waddr_error : raddr_error.
  - Register rsp_rdata = write ? 0 : rdata. On a read error, rdata is whatever the slave holds; it is passed through unmodified.
  - Increment err_count if the error is set; saturate at all-ones.
  - Go to RESP.
- **RESP**
  - rsp_valid=1. Hold all rsp_* stable until rsp_ready.
  - On rsp_ready: rsp_valid drops and the FSM goes to IDLE.
- Invariants:
  - ren and wen are never both 1.
  - At most one strobe per command.
  - addr and wdata hold their last value when strobes are low.
  - cmd_ready=1 only in IDLE, so there is at most one transaction in flight.
- Reset values (srst=1 at a rising edge):
  - state=IDLE.
  - ren, wen, rsp_valid, rsp_write, rsp_error = 0.
  - addr, wdata, rsp_rdata = 0.
  - err_count = 0.
  - cmd_ready = 1 from the first cycle after reset.
- Reset mid-transaction drops the transaction with no response.
  - If reset hits in ISSUE, the slave may already have committed the write. That is accepted behaviour.
  - srst overrides all other events in the same cycle.

## Timing
- Cycle 0: cmd handshake.
- Cycle 1: ren/wen high.
- Cycle 2: capture.
- Cycle 3: rsp_valid high at the earliest.
- Minimum command-to-command spacing is 4 cycles, when rsp_ready=1 throughout RESP.
- A new command may be accepted in the cycle immediately after the rsp handshake.
- rsp_ready asserted before RESP has no effect.
- All outputs are registered except cmd_ready, which is decoded from the state register.

## Structure
- Shared package average_csr_pkg holds:
  - state enum (IDLE/ISSUE/CAPTURE/RESP);
  - register offset constants ADDR_COUNT=12'h000, ADDR_INDEX_HI=12'h004, ADDR_INDEX_LO=12'h008;
  - ADDR_BITS/DATA_BITS defaults.
- No sub-module. Single FSM plus datapath registers.
- The bench instantiates average_slave_0 as the responder.

## Test plan
- Write 0x000 ← 0x12345678, then read 0x000 → rsp_write=1/rsp_error=0, then rsp_rdata=0x12345678, rsp_error=0. ren/wen each high exactly one cycle.
- Write 0x00C ← 0xDEADBEEF → rsp_error=1, err_count=1. Reads of 0x000/0x004/0x008 show registers unchanged.
- Read 0x010 after a read of 0x004 that returned 0xCAFE0001 → rsp_error=1, rsp_rdata=0xCAFE0001 (passed through), err_count incremented.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_* stable, cmd_ready=0, no ren/wen pulses. Release → next command accepted the following cycle. Spacing is exactly 4 cycles with rsp_ready tied high.
- Set ERR_COUNT_BITS=2 and issue 5 bad-address commands → err_count=3 (saturated).
- Assert srst during ISSUE of a write of 0x004 ← 0x55 → next cycle all outputs at reset values, no rsp_valid. A follow-up read of 0x004 completes normally.

Source files
------------

// File: rtl/average_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : average_csr_pkg
// Purpose  : Shared types and constants for the average accelerator CSR port.
// Revision : 1.0
// ============================================================================
package average_csr_pkg;

    localparam int DEF_ADDR_BITS = 12;
    localparam int DEF_DATA_BITS = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

    localparam logic [DEF_ADDR_BITS-1:0] ADDR_COUNT    = 12'h000;
    localparam logic [DEF_ADDR_BITS-1:0] ADDR_INDEX_HI = 12'h004;
    localparam logic [DEF_ADDR_BITS-1:0] ADDR_INDEX_LO = 12'h008;

endpackage : average_csr_pkg
`default_nettype wire

// File: rtl/average_csr_master.sv
`default_nettype none
// ============================================================================
// Module   : average_csr_master
// Purpose  : Single-outstanding bus initiator for the average register block.
// Revision : 1.0
// ============================================================================
module average_csr_master
    import average_csr_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int ERR_COUNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BITS-1:0]      cmd_addr,
    input  logic [DATA_BITS-1:0]      cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_BITS-1:0]      rsp_rdata,
    output logic                      rsp_error,
    output logic [ADDR_BITS-1:0]      addr,
    output logic                      ren,
    output logic                      wen,
    output logic [DATA_BITS-1:0]      wdata,
    input  logic [DATA_BITS-1:0]      rdata,
    input  logic                      waddr_error,
    input  logic                      raddr_error,
    output logic [ERR_COUNT_BITS-1:0] err_count
);

    state_t                    r_state;
    logic                      r_write;
    logic [ADDR_BITS-1:0]      r_addr;
    logic [DATA_BITS-1:0]      r_wdata;
    logic                      r_ren;
    logic                      r_wen;
    logic                      r_rsp_valid;
    logic                      r_rsp_write;
    logic [DATA_BITS-1:0]      r_rsp_rdata;
    logic                      r_rsp_error;
    logic [ERR_COUNT_BITS-1:0] r_err_count;

    logic                      w_err;

    // Error flag from the slave matching the direction of the command in flight.
    assign w_err = r_write ? waddr_error : raddr_error;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wen   <= cmd_write;
                        r_ren   <= ~cmd_write;
                        r_write <= cmd_write;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_ren   <= 1'b0;
                    r_wen   <= 1'b0;
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rsp_write <= r_write;
                    r_rsp_error <= w_err;
                    r_rsp_rdata <= r_write ? '0 : rdata;
                    if (w_err && !(&r_err_count)) begin
                        r_err_count <= r_err_count + ERR_COUNT_BITS'(1);
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign addr      = r_addr;
    assign ren       = r_ren;
    assign wen       = r_wen;
    assign wdata     = r_wdata;
    assign err_count = r_err_count;

endmodule : average_csr_master
`default_nettype wire
